// File: rtl/fp_result_wb.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_wb
// Brief    : FPU writeback stage. Buffers rounded results and their IEEE
//            flags in a small in-order FIFO, retires them to the register
//            file, and keeps the architectural sticky exception register.
//            Optional macro FPU_TRAP_EN adds per-flag trapping with a
//            pipeline stall until the trap is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_wb #(
    parameter int DEPTH = 2,   // 2 or 4 entries
    parameter int FLAGW = 5    // [4] INV, [3] DBZ, [2] OVF, [1] UNF, [0] INX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                fp_in,
    input  logic [FLAGW-1:0]           ieee_in,
    input  logic                       db_in,
    input  logic [4:0]                 tag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                fp_out,
    output logic                       db_out,
    output logic [4:0]                 tag_out,
    output logic [FLAGW-1:0]           ieee_out,
    input  logic                       flags_wr,
    input  logic [FLAGW-1:0]           flags_wdata,
    output logic [FLAGW-1:0]           sticky_flags,
    output logic [$clog2(DEPTH):0]     count
`ifdef FPU_TRAP_EN
    ,
    input  logic [FLAGW-1:0]           trap_en,
    output logic                       trap,
    output logic [FLAGW-1:0]           trap_cause,
    input  logic                       trap_ack
`endif
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    // Entry storage, one array per field
    logic [63:0]      fp_mem   [DEPTH];
    logic [FLAGW-1:0] ieee_mem [DEPTH];
    logic             db_mem   [DEPTH];
    logic [4:0]       tag_mem  [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [FLAGW-1:0] r_sticky;

    logic             w_push;
    logic             w_pop;
    logic             w_stall;
    logic [63:0]      w_fp_store;

`ifdef FPU_TRAP_EN
    logic             r_trap;
    logic [FLAGW-1:0] r_trap_cause;

    // A pending trap freezes both sides of the FIFO
    assign w_stall    = r_trap;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;
`else
    assign w_stall    = 1'b0;
`endif

    // Handshake decode; in_ready looks only at registered occupancy
    assign in_ready  = (r_count < C_DEPTH) & ~w_stall;
    assign out_valid = (r_count != '0) & ~w_stall;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Single-precision results are replicated into both halves on entry
    assign w_fp_store = db_in ? fp_in : {fp_in[31:0], fp_in[31:0]};

    // Head entry comes straight from storage at the read pointer
    assign fp_out       = fp_mem[r_rd_ptr];
    assign db_out       = db_mem[r_rd_ptr];
    assign tag_out      = tag_mem[r_rd_ptr];
    assign ieee_out     = ieee_mem[r_rd_ptr];
    assign count        = r_count;
    assign sticky_flags = r_sticky;

    // Entry storage write; cleared on reset so head fields read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fp_mem[i]   <= '0;
                ieee_mem[i] <= '0;
                db_mem[i]   <= 1'b0;
                tag_mem[i]  <= '0;
            end
        end else if (w_push) begin
            fp_mem[r_wr_ptr]   <= w_fp_store;
            ieee_mem[r_wr_ptr] <= ieee_in;
            db_mem[r_wr_ptr]   <= db_in;
            tag_mem[r_wr_ptr]  <= tag_in;
        end
    end

    // Pointers (natural power-of-two wrap) and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: software write lands first, retiring flags OR on top
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (flags_wr ? flags_wdata : r_sticky)
                      | (w_pop ? ieee_out : '0);
        end
    end

`ifdef FPU_TRAP_EN
    // Trap capture on retirement of an enabled flag; cleared by ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap       <= 1'b0;
            r_trap_cause <= '0;
        end else if (w_pop && ((ieee_out & trap_en) != '0)) begin
            r_trap       <= 1'b1;
            r_trap_cause <= ieee_out & trap_en;
        end else if (r_trap && trap_ack) begin
            r_trap       <= 1'b0;
            r_trap_cause <= '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_result_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_wb
// Brief    : Self-checking bench for fp_result_wb (DEPTH=2, FLAGW=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_result_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp_in;
    logic [4:0]  ieee_in;
    logic        db_in;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic        db_out;
    logic [4:0]  tag_out;
    logic [4:0]  ieee_out;
    logic        flags_wr;
    logic [4:0]  flags_wdata;
    logic [4:0]  sticky_flags;
    logic [1:0]  count;
`ifdef FPU_TRAP_EN
    logic [4:0]  trap_en;
    logic        trap;
    logic [4:0]  trap_cause;
    logic        trap_ack;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fp_result_wb #(.DEPTH(2), .FLAGW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fp_in        (fp_in),
        .ieee_in      (ieee_in),
        .db_in        (db_in),
        .tag_in       (tag_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fp_out       (fp_out),
        .db_out       (db_out),
        .tag_out      (tag_out),
        .ieee_out     (ieee_out),
        .flags_wr     (flags_wr),
        .flags_wdata  (flags_wdata),
        .sticky_flags (sticky_flags),
        .count        (count)
`ifdef FPU_TRAP_EN
        ,
        .trap_en      (trap_en),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .trap_ack     (trap_ack)
`endif
    );

    typedef struct {
        logic [63:0] fp;
        logic        db;
        logic [4:0]  tag;
        logic [4:0]  ieee;
        logic [63:0] exp_fp;
        logic [4:0]  exp_sticky;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        fp_in       = '0;
        ieee_in     = '0;
        db_in       = 1'b1;
        tag_in      = '0;
        out_ready   = 1'b0;
        flags_wr    = 1'b0;
        flags_wdata = '0;
`ifdef FPU_TRAP_EN
        trap_en     = '0;
        trap_ack    = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [63:0] f, input logic d, input logic [4:0] t, input logic [4:0] e);
        in_valid = 1'b1;
        fp_in    = f;
        db_in    = d;
        tag_in   = t;
        ieee_in  = e;
    endtask

    logic [4:0] prev_sticky;

    initial begin
        vecs[0] = '{64'h3FF0000000000000, 1'b1, 5'd3,  5'b00000, 64'h3FF0000000000000, 5'b00000};
        vecs[1] = '{64'hDEADBEEF3F800000, 1'b0, 5'd7,  5'b00000, 64'h3F8000003F800000, 5'b00000};
        vecs[2] = '{64'hC000000000000000, 1'b1, 5'd1,  5'b00001, 64'hC000000000000000, 5'b00001};
        vecs[3] = '{64'h123456789ABCDEF0, 1'b0, 5'd31, 5'b00100, 64'h9ABCDEF09ABCDEF0, 5'b00101};
        vecs[4] = '{64'h7FF8000000000000, 1'b1, 5'd0,  5'b10000, 64'h7FF8000000000000, 5'b10101};

        do_reset();

        // Reset state
        chk("rst_count",     64'(count),        64'd0);
        chk("rst_out_valid", 64'(out_valid),    64'd0);
        chk("rst_in_ready",  64'(in_ready),     64'd1);
        chk("rst_sticky",    64'(sticky_flags), 64'd0);
        chk("rst_fp_out",    fp_out,            64'd0);
        chk("rst_tag_out",   64'(tag_out),      64'd0);

        // Latency with out_ready held high: no bypass, visible one cycle later
        out_ready = 1'b1;
        drive(64'h3FF0000000000000, 1'b1, 5'd3, 5'b00000);
        chk("lat_no_bypass", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_fp",    fp_out,         64'h3FF0000000000000);
        chk("lat_tag",   64'(tag_out),   64'd3);
        tick();
        chk("lat_count",  64'(count),        64'd0);
        chk("lat_sticky", 64'(sticky_flags), 64'd0);

        // Table: push with out_ready low, inspect head, then retire
        do_reset();
        prev_sticky = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            drive(vecs[i].fp, vecs[i].db, vecs[i].tag, vecs[i].ieee);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i),  64'(out_valid),    64'd1);
            chk($sformatf("v%0d_fp", i),     fp_out,            vecs[i].exp_fp);
            chk($sformatf("v%0d_db", i),     64'(db_out),       64'(vecs[i].db));
            chk($sformatf("v%0d_tag", i),    64'(tag_out),      64'(vecs[i].tag));
            chk($sformatf("v%0d_ieee", i),   64'(ieee_out),     64'(vecs[i].ieee));
            chk($sformatf("v%0d_nopush_acc", i), 64'(sticky_flags), 64'(prev_sticky));
            out_ready = 1'b1;
            tick();
            chk($sformatf("v%0d_count", i),  64'(count),        64'd0);
            chk($sformatf("v%0d_sticky", i), 64'(sticky_flags), 64'(vecs[i].exp_sticky));
            prev_sticky = vecs[i].exp_sticky;
        end

        // Software write alone, then clear racing a flagged retirement
        out_ready   = 1'b0;
        flags_wr    = 1'b1;
        flags_wdata = 5'b00011;
        tick();
        flags_wr = 1'b0;
        chk("sw_write", 64'(sticky_flags), 64'h03);
        drive(64'h1, 1'b1, 5'd2, 5'b10000);
        tick();
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        flags_wr    = 1'b1;
        flags_wdata = 5'b00000;
        tick();
        flags_wr = 1'b0;
        chk("clr_with_pop", 64'(sticky_flags), 64'h10);

        // Full FIFO blocks the third push, then drains in order
        do_reset();
        drive(64'hA, 1'b1, 5'd1, 5'b0);
        tick();
        drive(64'hB, 1'b1, 5'd2, 5'b0);
        tick();
        drive(64'hC, 1'b1, 5'd3, 5'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count",    64'(count),    64'd2);
        tick();
        chk("full_blocked",  64'(count),    64'd2);
        chk("full_head_a",   fp_out,        64'hA);
        out_ready = 1'b1;
        chk("full_pop_no_push", 64'(in_ready), 64'd0);
        tick();
        chk("drain1_count", 64'(count),   64'd1);
        chk("drain1_head",  fp_out,       64'hB);
        chk("drain1_tag",   64'(tag_out), 64'd2);
        tick();
        chk("drain2_count", 64'(count),   64'd1);
        chk("drain2_head",  fp_out,       64'hC);
        drive(64'hD, 1'b1, 5'd4, 5'b0);
        tick();
        in_valid = 1'b0;
        chk("drain3_head",  fp_out,       64'hD);
        tick();
        chk("drain_empty",  64'(count),   64'd0);

        // Streaming: one result per cycle, occupancy never above 1
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(64'(k) + 64'h100, 1'b1, 5'(k), 5'b0);
            if (k > 0) begin
                chk($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
                chk($sformatf("stream%0d_fp", k),    fp_out,          64'(k - 1) + 64'h100);
                chk($sformatf("stream%0d_cnt", k),   64'(count <= 2'd1), 64'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream_last", fp_out, 64'h10F);
        tick();
        chk("stream_empty", 64'(count), 64'd0);

        // Reset mid-operation discards entries; nothing retires
        do_reset();
        drive(64'h5, 1'b1, 5'd5, 5'b01000);
        tick();
        drive(64'h6, 1'b1, 5'd6, 5'b00010);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count",  64'(count),        64'd0);
        chk("midrst_valid",  64'(out_valid),    64'd0);
        chk("midrst_sticky", 64'(sticky_flags), 64'd0);
        chk("midrst_fp",     fp_out,            64'd0);

`ifdef FPU_TRAP_EN
        // Trap on enabled flag: stall with one entry held, release on ack
        do_reset();
        trap_en = 5'b00100;
        drive(64'hE1, 1'b1, 5'd8, 5'b00101);
        tick();
        drive(64'hE2, 1'b1, 5'd9, 5'b00000);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("trap_set",      64'(trap),         64'd1);
        chk("trap_cause",    64'(trap_cause),   64'h04);
        chk("trap_sticky",   64'(sticky_flags), 64'h05);
        chk("trap_in_ready", 64'(in_ready),     64'd0);
        chk("trap_valid",    64'(out_valid),    64'd0);
        chk("trap_count",    64'(count),        64'd1);
        tick();
        chk("trap_hold",     64'(count),        64'd1);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk("trap_clr",      64'(trap),         64'd0);
        chk("trap_cause_clr", 64'(trap_cause),  64'd0);
        chk("trap_resume",   64'(out_valid),    64'd1);
        chk("trap_head",     fp_out,            64'hE2);
        tick();
        chk("trap_drained",  64'(count),        64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_result_wb.md
Name: fp_result_wb

Overview:
- Writeback stage directly downstream of the special-case/rounding select stage.
- Accepts the packed 64-bit result and 5-bit IEEE flag vector through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Retires results to the register-file write port in order.
- Keeps the architectural sticky exception-flag register, which software can read and write.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4 only.
- FLAGW, 5, width of the IEEE flag vector. Bit order: [4] INV, [3] DBZ, [2] OVF, [1] UNF, [0] INX.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  rounder result valid.
- in_ready  out  1  stage can accept.
- fp_in  in  64  packed result from the rounder (double, or single replicated in both halves).
- ieee_in  in  FLAGW  exception flags for fp_in.
- db_in  in  1  1 = double precision, 0 = single.
- tag_in  in  5  destination register index.
- out_valid  out  1  result available for writeback.
- out_ready  in  1  register file accepts.
- fp_out  out  64  result; in single mode, bits [63:32] are driven with bits [31:0].
- db_out  out  1  precision of the head entry.
- tag_out  out  5  destination of the head entry.
- ieee_out  out  FLAGW  flags of the head entry.
- flags_wr  in  1  software write of the sticky register.
- flags_wdata  in  FLAGW  write data.
- sticky_flags  out  FLAGW  accrued exception flags.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- trap_en  in  FLAGW  per-flag trap enable (present only with FPU_TRAP_EN).
- trap  out  1  trap pending (present only with FPU_TRAP_EN).
- trap_cause  out  FLAGW  flags that caused the trap (present only with FPU_TRAP_EN).
- trap_ack  in  1  clears the trap (present only with FPU_TRAP_EN).

Behaviour:
- Reset (rst=1 at a clk edge): count=0, out_valid=0, sticky_flags=0, trap=0, trap_cause=0. Read/write pointers go to 0. fp_out/tag_out/ieee_out/db_out = 0.
- Reset mid-operation discards all buffered entries; nothing retires in the reset cycle.
- Push: in_valid & in_ready. in_ready = (count < DEPTH), combinational from registered count only; it does not look ahead at out_ready.
- Pop: out_valid & out_ready. out_valid = (count != 0).
- Head fields (fp_out, tag_out, ieee_out, db_out) are driven from the registered read entry, stable while out_valid & ~out_ready.
- Latency: an entry pushed at edge N is visible on out_valid after edge N, i.e. one cycle minimum. Back-to-back push/pop sustains 1 result per cycle.
- Simultaneous push and pop at full: the push is not accepted because in_ready=0. At empty: no bypass, so the pop waits a cycle.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Single-precision normalisation: on push with db_in=0, the stored word is {fp_in[31:0], fp_in[31:0]}; the upper half of the input is ignored.
- Sticky register is updated at the clk edge:
  - next = (flags_wr ? flags_wdata : sticky_flags) | (pop ? ieee_out : 0).
  - Flags accrue at retirement, never at push.
  - A software write in the same cycle as a pop keeps the popped flags (write first, then OR).
  - Clearing with flags_wdata=0 while a flagged result retires leaves that result's flags set.
- Flags of entries still in the FIFO are not visible in sticky_flags.

Optional Feature:
- Macro: FPU_TRAP_EN.
- Defined:
  - On a pop where ieee_out & trap_en != 0, trap=1 and trap_cause=ieee_out & trap_en are registered at that edge.
  - The trapping result still retires and still accrues into sticky_flags.
  - While trap=1, out_valid is forced 0 and in_ready is forced 0; the FIFO contents are held.
  - trap_ack=1 clears trap and trap_cause at the next edge. The ack is ignored when trap=0.
  - rst overrides trap_ack.
- Undefined: the trap_en, trap, trap_cause and trap_ack ports do not exist, and there is no stall logic.

Test Plan:
1. Reset, then push fp_in=64'h3FF0000000000000, db=1, tag=3, ieee=0 with out_ready=1 -> out_valid rises one cycle later with the same data and tag 3; count returns to 0; sticky_flags=0.
2. out_ready=0, push 3 entries with DEPTH=2 -> third push blocked (in_ready=0 at count=2); release out_ready -> entries retire in order, and 2 cycles of in_valid are accepted once space frees.
3. Push single fp_in=64'hDEADBEEF_3F800000, db=0 -> fp_out=64'h3F800000_3F800000, db_out=0.
4. Retire ieee=5'b00001, then ieee=5'b00100 -> sticky_flags=5'b00001, then 5'b00101. Next, flags_wr=1 with flags_wdata=0 in the same cycle a 5'b10000 entry pops -> sticky_flags=5'b10000.
5. Continuous push/pop with out_ready=1 for 16 cycles -> 16 results retire in order at 1/cycle, and count never exceeds 1.
6. (FPU_TRAP_EN) trap_en=5'b00100, retire ieee=5'b00101 -> trap=1, trap_cause=5'b00100, sticky includes 5'b00101, and in_ready/out_valid stay 0 with 1 entry held. Then trap_ack=1 -> trap=0, and the held entry retires next cycle.
